// File: rtl/i2c_util_pkg.sv
// Shared definitions for the I2C register target: register map, control bit
// positions, protocol state encoding and the register read-back mux.
package i2c_util;

  localparam logic [7:0] REG_CFG_FIRST = 8'd7;    // regs 7..12 hold the oscillator config
  localparam int         CFG_BYTES     = 6;
  localparam logic [7:0] REG_CTRL      = 8'd135;
  localparam logic [7:0] REG_FREEZE    = 8'd137;

  localparam int BIT_RECALL  = 0;
  localparam int BIT_NEWFREQ = 6;
  localparam int BIT_FREEZE  = 4;

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK
  } state_t;

  function automatic logic is_byte_state(input state_t s);
    return (s == ADDR) || (s == PTR) || (s == WDATA) || (s == RDATA);
  endfunction

  // Register 135 is write-only strobes, so it always reads back as zero.
  function automatic logic [7:0] reg_read(input logic [7:0] addr, input logic [47:0] cfg,
                                          input logic freeze);
    logic [7:0] val;
    val = 8'h00;
    for (int i = 0; i < CFG_BYTES; i++)
      if (addr == REG_CFG_FIRST + 8'(i)) val = cfg[47 - 8*i -: 8];
    if (addr == REG_FREEZE) val[BIT_FREEZE] = freeze;
    return val;
  endfunction

endpackage

// File: rtl/i2c_glitch_filter.sv
// Two-flop synchronizer followed by a persistence filter: the output only
// follows the input after FilterCycles consecutive differing samples.
module i2c_glitch_filter #(
  parameter int FilterCycles = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  localparam int CntW = (FilterCycles > 1) ? $clog2(FilterCycles) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(FilterCycles - 1);

  logic [1:0]      sync_reg;
  logic [CntW-1:0] cnt_reg;
  logic            filt_reg;

  // Idle I2C lines are high, so everything powers up as if the bus were idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_reg <= 2'b11;
      cnt_reg  <= '0;
      filt_reg <= 1'b1;
    end else begin
      sync_reg <= {sync_reg[0], din};
      if (sync_reg[1] == filt_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CntMax) begin
        filt_reg <= sync_reg[1];
        cnt_reg  <= '0;
      end else begin
        cnt_reg <= cnt_reg + CntW'(1);
      end
    end
  end

  assign dout = filt_reg;

endmodule

// File: rtl/i2c_reg_target.sv
// I2C target exposing the oscillator config registers (7..12), a control
// strobe register (135) and the DCO freeze bit (137), with pointer auto-increment.
module i2c_reg_target
  import i2c_util::*;
#(
  parameter logic [6:0]  I2CAddress    = 7'h55,
  parameter logic [47:0] FactoryConfig = 48'h01C2_BC01_1EB8,
  parameter int          FilterCycles  = 3
) (
  input  logic        clk,
  input  logic        reset,
  inout  tri1         scl,
  inout  tri1         sda,
  output logic [2:0]  hs_div,
  output logic [6:0]  n1,
  output logic [37:0] rfreq,
  output logic        freeze_dco,
  output logic        new_freq,
  output logic        bus_error
);

  logic [1:0] line_raw;
  logic [1:0] line_filt;
  assign line_raw = {sda, scl};

  for (genvar gi = 0; gi < 2; gi++) begin : g_filt
    i2c_glitch_filter #(.FilterCycles(FilterCycles)) u_filt (
      .clk  (clk),
      .reset(reset),
      .din  (line_raw[gi]),
      .dout (line_filt[gi])
    );
  end

  state_t      state_reg;
  logic        scl_q_reg, sda_q_reg, sda_low_reg, rise_seen_reg, rw_reg, ack_reg;
  logic        freeze_reg, new_freq_reg, bus_error_reg;
  logic [2:0]  bit_cnt_reg;
  logic [7:0]  rx_reg, tx_reg, ptr_reg;
  logic [47:0] cfg_reg;
  logic        scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det;
  logic [7:0]  rd_cur, rd_next;

  assign scl_f     = line_filt[0];
  assign sda_f     = line_filt[1];
  assign scl_rise  = scl_f & ~scl_q_reg;
  assign scl_fall  = ~scl_f & scl_q_reg;
  assign start_det = scl_f & scl_q_reg & sda_q_reg & ~sda_f;
  assign stop_det  = scl_f & scl_q_reg & ~sda_q_reg & sda_f;
  assign rd_cur    = reg_read(ptr_reg, cfg_reg, freeze_reg);
  assign rd_next   = reg_read(ptr_reg + 8'd1, cfg_reg, freeze_reg);

  // bit_cnt counts completed bit slots (a rise followed by a fall), so the
  // rise that precedes a normal STOP/repeated START is not a partial byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      scl_q_reg     <= 1'b1;
      sda_q_reg     <= 1'b1;
      sda_low_reg   <= 1'b0;
      rise_seen_reg <= 1'b0;
      rw_reg        <= 1'b0;
      ack_reg       <= 1'b0;
      bit_cnt_reg   <= 3'd0;
      rx_reg        <= 8'h00;
      tx_reg        <= 8'h00;
      ptr_reg       <= 8'h00;
      cfg_reg       <= FactoryConfig;
      freeze_reg    <= 1'b0;
      new_freq_reg  <= 1'b0;
      bus_error_reg <= 1'b0;
    end else begin
      scl_q_reg     <= scl_f;
      sda_q_reg     <= sda_f;
      new_freq_reg  <= 1'b0;
      bus_error_reg <= 1'b0;
      if (start_det || stop_det) begin
        if (is_byte_state(state_reg) && bit_cnt_reg != 3'd0) bus_error_reg <= 1'b1;
        state_reg     <= start_det ? ADDR : IDLE;
        sda_low_reg   <= 1'b0;
        bit_cnt_reg   <= 3'd0;
        rise_seen_reg <= 1'b0;
      end else if (scl_rise) begin
        rx_reg        <= {rx_reg[6:0], sda_f};
        rise_seen_reg <= 1'b1;
        if (state_reg == RDATA_ACK) ack_reg <= ~sda_f;
      end else if (scl_fall) begin
        rise_seen_reg <= 1'b0;
        case (state_reg)
          ADDR, PTR, WDATA: if (rise_seen_reg) begin
            if (bit_cnt_reg != 3'd7) begin
              bit_cnt_reg <= bit_cnt_reg + 3'd1;
            end else begin
              bit_cnt_reg <= 3'd0;
              sda_low_reg <= 1'b1;
              if (state_reg == ADDR) begin
                rw_reg <= rx_reg[0];
                if (rx_reg[7:1] == I2CAddress) begin
                  state_reg <= ADDR_ACK;
                end else begin
                  state_reg   <= IDLE;
                  sda_low_reg <= 1'b0;
                end
              end else if (state_reg == PTR) begin
                ptr_reg   <= rx_reg;
                state_reg <= PTR_ACK;
              end else begin
                for (int i = 0; i < CFG_BYTES; i++)
                  if (ptr_reg == REG_CFG_FIRST + 8'(i)) cfg_reg[47 - 8*i -: 8] <= rx_reg;
                if (ptr_reg == REG_CTRL) begin
                  if (rx_reg[BIT_RECALL]) cfg_reg <= FactoryConfig;
                  new_freq_reg <= rx_reg[BIT_NEWFREQ];
                end
                if (ptr_reg == REG_FREEZE) freeze_reg <= rx_reg[BIT_FREEZE];
                ptr_reg   <= ptr_reg + 8'd1;
                state_reg <= WDATA_ACK;
              end
            end
          end
          ADDR_ACK: begin
            if (rw_reg) begin
              tx_reg      <= rd_cur;
              sda_low_reg <= ~rd_cur[7];
              state_reg   <= RDATA;
            end else begin
              sda_low_reg <= 1'b0;
              state_reg   <= PTR;
            end
          end
          PTR_ACK, WDATA_ACK: begin
            sda_low_reg <= 1'b0;
            state_reg   <= WDATA;
          end
          RDATA: if (rise_seen_reg) begin
            if (bit_cnt_reg != 3'd7) begin
              bit_cnt_reg <= bit_cnt_reg + 3'd1;
              sda_low_reg <= ~tx_reg[6];
              tx_reg      <= {tx_reg[6:0], 1'b0};
            end else begin
              bit_cnt_reg <= 3'd0;
              sda_low_reg <= 1'b0;
              state_reg   <= RDATA_ACK;
            end
          end
          RDATA_ACK: begin
            if (ack_reg) begin
              ptr_reg     <= ptr_reg + 8'd1;
              tx_reg      <= rd_next;
              sda_low_reg <= ~rd_next[7];
              state_reg   <= RDATA;
            end else begin
              sda_low_reg <= 1'b0;
              state_reg   <= IDLE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign sda        = sda_low_reg ? 1'b0 : 1'bz;
  assign hs_div     = cfg_reg[47:45];
  assign n1         = cfg_reg[44:38];
  assign rfreq      = cfg_reg[37:0];
  assign freeze_dco = freeze_reg;
  assign new_freq   = new_freq_reg;
  assign bus_error  = bus_error_reg;

endmodule
